fwrd_bypass_buffer: RTL and testbench

//  Parametrised forwarding unit for the register-read stage. Holds writeback results in a

---
 rtl/fwrd_bypass_buffer_pkg.sv | 20 ++
 rtl/fwrd_bypass_buffer_match_sel.sv | 25 ++
 rtl/fwrd_bypass_buffer.sv | 122 ++++++++++++
 tb/tb_fwrd_bypass_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrd_bypass_buffer_pkg.sv
// Shared types and constants for the register-read forwarding unit.
package fwrd_bypass_buffer_pkg;

    localparam int NUM_PREGS  = 64;
    localparam int PREG_W     = $clog2(NUM_PREGS);
    localparam int FWRD_DEPTH = 2;

    // One forwardable writeback result
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] preg;
        logic [31:0]       data;
    } fwrd_entry_t;

    // preg 0 is the hardwired-zero register and never forwards
    function automatic logic fwrd_entry_hit(input fwrd_entry_t e, input logic [PREG_W-1:0] tag);
        return e.valid && (e.preg == tag) && (tag != '0);
    endfunction

endpackage

// File: rtl/fwrd_bypass_buffer_match_sel.sv
// One source tag against a priority-ordered entry list (index 0 = youngest/highest).
module fwrd_match_sel
    import fwrd_bypass_buffer_pkg::*;
#(
    parameter int N_ENT = 4
) (
    input  logic [PREG_W-1:0]       tag,
    input  fwrd_entry_t [N_ENT-1:0] ent,
    output logic                    hit,
    output logic [31:0]             val
);

    // Walk from lowest to highest priority so the last match written wins
    always_comb begin
        hit = 1'b0;
        val = 32'h0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (fwrd_entry_hit(ent[i], tag)) begin
                hit = 1'b1;
                val = ent[i].data;
            end
        end
    end

endmodule

// File: rtl/fwrd_bypass_buffer.sv
// Forwarding unit: DEPTH-stage age buffer of writebacks, NUM_RD read ports x 2 sources,
// optional same-cycle bypass, flush, and a saturating hit counter.
module fwrd_bypass_buffer
    import fwrd_bypass_buffer_pkg::*;
#(
    parameter int NUM_RD   = 2,
    parameter int NUM_WB   = 2,
    parameter int DEPTH    = FWRD_DEPTH,
    parameter int COMB_BYP = 1,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PREG_W-1:0] wb_preg,
    input  logic [NUM_WB*32-1:0]     wb_data,
    input  logic [NUM_RD*PREG_W-1:0] src1_reg,
    input  logic [NUM_RD*PREG_W-1:0] src2_reg,
    output logic [NUM_RD-1:0]        src1_fwrd_hit,
    output logic [NUM_RD*32-1:0]     src1_val,
    output logic [NUM_RD-1:0]        src2_fwrd_hit,
    output logic [NUM_RD*32-1:0]     src2_val,
    output logic [CNT_W-1:0]         hit_count
);

    localparam int BYP   = (COMB_BYP != 0) ? 1 : 0;
    localparam int N_AGE = DEPTH + BYP;
    localparam int N_ENT = N_AGE * NUM_WB;

    fwrd_entry_t [NUM_WB-1:0]            wb_ent;
    fwrd_entry_t [DEPTH-1:0][NUM_WB-1:0] stage_q;
    fwrd_entry_t [N_ENT-1:0]             ent_list;

    // Pack the incoming writeback channels into entries
    always_comb begin
        for (int c = 0; c < NUM_WB; c++) begin
            wb_ent[c].valid = wb_valid[c];
            wb_ent[c].preg  = wb_preg[c*PREG_W +: PREG_W];
            wb_ent[c].data  = wb_data[c*32 +: 32];
        end
    end

    // Age shift register; flush/reset only kill valids, payload is don't-care
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++)
                for (int c = 0; c < NUM_WB; c++)
                    stage_q[i][c].valid <= 1'b0;
        end else begin
            stage_q[0] <= wb_ent;
            for (int i = 1; i < DEPTH; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    // Flatten youngest-first; within an age the highest channel comes first
    generate
        for (genvar a = 0; a < N_AGE; a++) begin : g_age
            for (genvar c = 0; c < NUM_WB; c++) begin : g_ch
                if (BYP != 0 && a == 0) begin : g_cur
                    assign ent_list[a*NUM_WB + (NUM_WB-1-c)] = wb_ent[c];
                end else begin : g_stg
                    assign ent_list[a*NUM_WB + (NUM_WB-1-c)] = stage_q[a-BYP][c];
                end
            end
        end
    endgenerate

    // One matcher per source per read port
    generate
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            fwrd_match_sel #(.N_ENT(N_ENT)) u_src1 (
                .tag (src1_reg[r*PREG_W +: PREG_W]),
                .ent (ent_list),
                .hit (src1_fwrd_hit[r]),
                .val (src1_val[r*32 +: 32])
            );
            fwrd_match_sel #(.N_ENT(N_ENT)) u_src2 (
                .tag (src2_reg[r*PREG_W +: PREG_W]),
                .ent (ent_list),
                .hit (src2_fwrd_hit[r]),
                .val (src2_val[r*32 +: 32])
            );
        end
    endgenerate

    logic [CNT_W:0] hit_pop;
    logic [CNT_W:0] hit_sum;

    // Count of source hits this cycle and the widened running total
    always_comb begin
        hit_pop = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            hit_pop = hit_pop + {{CNT_W{1'b0}}, src1_fwrd_hit[r]}
                              + {{CNT_W{1'b0}}, src2_fwrd_hit[r]};
        end
        hit_sum = {1'b0, hit_count} + hit_pop;
    end

    // Saturating hit statistics; the carry bit marks overflow
    always_ff @(posedge clk) begin
        if (rst)
            hit_count <= '0;
        else if (hit_sum[CNT_W])
            hit_count <= '1;
        else
            hit_count <= hit_sum[CNT_W-1:0];
    end

    // Two channels writing the same nonzero preg in one cycle cannot happen after renaming
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WB; i++)
                for (int j = i + 1; j < NUM_WB; j++)
                    assert (!(wb_valid[i] && wb_valid[j] &&
                              wb_preg[i*PREG_W +: PREG_W] == wb_preg[j*PREG_W +: PREG_W] &&
                              wb_preg[i*PREG_W +: PREG_W] != '0));
        end
    end

endmodule

// File: tb/tb_fwrd_bypass_buffer.sv
// Bench: one bypass build (32b counter) and one buffered-only build (4b counter) on shared stimulus.
module tb_fwrd_bypass_buffer;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DP = 2;
    localparam int PW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, flush;
    logic [NW-1:0]       wb_valid;
    logic [NW*PW-1:0]    wb_preg;
    logic [NW*32-1:0]    wb_data;
    logic [NR*PW-1:0]    src1_reg, src2_reg;

    logic [NR-1:0]       a_s1h, a_s2h, b_s1h, b_s2h;
    logic [NR*32-1:0]    a_s1v, a_s2v, b_s1v, b_s2v;
    logic [31:0]         a_cnt;
    logic [3:0]          b_cnt;

    fwrd_bypass_buffer #(.NUM_RD(NR), .NUM_WB(NW), .DEPTH(DP), .COMB_BYP(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .wb_valid(wb_valid), .wb_preg(wb_preg),
        .wb_data(wb_data), .src1_reg(src1_reg), .src2_reg(src2_reg),
        .src1_fwrd_hit(a_s1h), .src1_val(a_s1v), .src2_fwrd_hit(a_s2h), .src2_val(a_s2v),
        .hit_count(a_cnt));

    fwrd_bypass_buffer #(.NUM_RD(NR), .NUM_WB(NW), .DEPTH(DP), .COMB_BYP(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .wb_valid(wb_valid), .wb_preg(wb_preg),
        .wb_data(wb_data), .src1_reg(src1_reg), .src2_reg(src2_reg),
        .src1_fwrd_hit(b_s1h), .src1_val(b_s1v), .src2_fwrd_hit(b_s2h), .src2_val(b_s2v),
        .hit_count(b_cnt));

    int compared = 0;
    int mismatched = 0;

    // Reference model: writebacks seen 1..DP cycles ago, plus running hit counts
    bit          hv [1:DP][0:NW-1];
    int          hp [1:DP][0:NW-1];
    logic [31:0] hd [1:DP][0:NW-1];
    longint      cnt_a = 0;
    int          cnt_b = 0;

    function automatic void ref_lookup(input int tag, input bit comb,
                                       output bit hit, output logic [31:0] val);
        hit = 1'b0;
        val = 32'h0;
        if (tag == 0) return;
        if (comb)
            for (int c = NW - 1; c >= 0; c--)
                if (wb_valid[c] && int'(wb_preg[c*PW +: PW]) == tag) begin
                    hit = 1'b1; val = wb_data[c*32 +: 32]; return;
                end
        for (int a = 1; a <= DP; a++)
            for (int c = NW - 1; c >= 0; c--)
                if (hv[a][c] && hp[a][c] == tag) begin
                    hit = 1'b1; val = hd[a][c]; return;
                end
    endfunction

    // Advance one clock, updating the model from the inputs that were applied
    task automatic tick();
        int pa, pb, tag;
        bit h;
        logic [31:0] v;
        pa = 0; pb = 0;
        for (int r = 0; r < NR; r++)
            for (int s = 0; s < 2; s++) begin
                tag = (s == 0) ? int'(src1_reg[r*PW +: PW]) : int'(src2_reg[r*PW +: PW]);
                ref_lookup(tag, 1'b1, h, v); pa += int'(h);
                ref_lookup(tag, 1'b0, h, v); pb += int'(h);
            end
        if (rst) begin
            cnt_a = 0; cnt_b = 0;
        end else begin
            cnt_a = cnt_a + pa;
            cnt_b = (cnt_b + pb > 15) ? 15 : cnt_b + pb;
        end
        if (rst || flush) begin
            for (int a = 1; a <= DP; a++)
                for (int c = 0; c < NW; c++) hv[a][c] = 1'b0;
        end else begin
            for (int a = DP; a >= 2; a--)
                for (int c = 0; c < NW; c++) begin
                    hv[a][c] = hv[a-1][c]; hp[a][c] = hp[a-1][c]; hd[a][c] = hd[a-1][c];
                end
            for (int c = 0; c < NW; c++) begin
                hv[1][c] = wb_valid[c];
                hp[1][c] = int'(wb_preg[c*PW +: PW]);
                hd[1][c] = wb_data[c*32 +: 32];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        flush = 1'b0; wb_valid = '0; wb_preg = '0; wb_data = '0;
        src1_reg = '0; src2_reg = '0;
    endtask

    task automatic put_wb(input int ch, input int p, input logic [31:0] d);
        wb_valid[ch] = 1'b1;
        wb_preg[ch*PW +: PW] = PW'(p);
        wb_data[ch*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_idle();
        tick(); tick();
        rst = 1'b0;
        src1_reg = {6'd5, 6'd5}; src2_reg = {6'd5, 6'd5};
        #1;
        compared++; if (a_s1h !== 2'b00 || a_s2h !== 2'b00) begin mismatched++; $display("FAIL reset_hit: got %b/%b want 00/00", a_s1h, a_s2h); end
        compared++; if (a_s1v !== '0) begin mismatched++; $display("FAIL reset_val: got %h want 0", a_s1v); end
        compared++; if (a_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_cnt_a: got %0d want 0", a_cnt); end
        compared++; if (b_cnt !== 4'd0 || b_s1h !== 2'b00) begin mismatched++; $display("FAIL reset_b: cnt %0d hit %b want 0/00", b_cnt, b_s1h); end
        tick();
    endtask

    task automatic test_comb_byp();
        set_idle();
        put_wb(0, 7, 32'hDEAD_BEEF);
        src1_reg[0 +: PW] = 6'd7;
        #1;
        compared++; if (a_s1h[0] !== 1'b1 || a_s1v[31:0] !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL byp_t0: got %b/%h want 1/deadbeef", a_s1h[0], a_s1v[31:0]); end
        compared++; if (b_s1h[0] !== 1'b0 || b_s1v[31:0] !== 32'h0) begin mismatched++; $display("FAIL nobyp_t0: got %b/%h want 0/0", b_s1h[0], b_s1v[31:0]); end
        tick();
        wb_valid = '0;
        for (int k = 1; k <= DP; k++) begin
            #1;
            compared++; if (a_s1h[0] !== 1'b1 || a_s1v[31:0] !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL byp_age%0d: got %b/%h want 1/deadbeef", k, a_s1h[0], a_s1v[31:0]); end
            compared++; if (b_s1h[0] !== 1'b1 || b_s1v[31:0] !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL nobyp_age%0d: got %b/%h want 1/deadbeef", k, b_s1h[0], b_s1v[31:0]); end
            tick();
        end
        #1;
        compared++; if (a_s1h[0] !== 1'b0 || a_s1v[31:0] !== 32'h0 || b_s1h[0] !== 1'b0) begin mismatched++; $display("FAIL byp_expire: got a %b/%h b %b want 0/0 0", a_s1h[0], a_s1v[31:0], b_s1h[0]); end
        tick();
    endtask

    task automatic test_priority();
        set_idle();
        put_wb(0, 9, 32'd1);
        tick();
        put_wb(0, 9, 32'd2);
        src2_reg[PW +: PW] = 6'd9;
        #1;
        compared++; if (a_s2h[1] !== 1'b1 || a_s2v[63:32] !== 32'd2) begin mismatched++; $display("FAIL prio_cur: got %b/%0d want 1/2", a_s2h[1], a_s2v[63:32]); end
        compared++; if (b_s2h[1] !== 1'b1 || b_s2v[63:32] !== 32'd1) begin mismatched++; $display("FAIL prio_b_t1: got %b/%0d want 1/1", b_s2h[1], b_s2v[63:32]); end
        tick();
        wb_valid = '0;
        #1;
        compared++; if (a_s2v[63:32] !== 32'd2 || b_s2v[63:32] !== 32'd2) begin mismatched++; $display("FAIL prio_stage: got %0d/%0d want 2/2", a_s2v[63:32], b_s2v[63:32]); end
        tick();
    endtask

    task automatic test_flush();
        set_idle();
        put_wb(0, 3, 32'hAA);
        tick();
        wb_valid = '0;
        flush = 1'b1;
        put_wb(1, 11, 32'h55);
        src1_reg[0 +: PW] = 6'd3;
        src2_reg[0 +: PW] = 6'd11;
        #1;
        compared++; if (a_s1h[0] !== 1'b1 || a_s1v[31:0] !== 32'hAA || b_s1v[31:0] !== 32'hAA) begin mismatched++; $display("FAIL flush_buf: got %b/%h b %h want 1/aa aa", a_s1h[0], a_s1v[31:0], b_s1v[31:0]); end
        compared++; if (a_s2h[0] !== 1'b1 || a_s2v[31:0] !== 32'h55 || b_s2h[0] !== 1'b0) begin mismatched++; $display("FAIL flush_cur: got %b/%h b %b want 1/55 0", a_s2h[0], a_s2v[31:0], b_s2h[0]); end
        tick();
        flush = 1'b0; wb_valid = '0;
        #1;
        compared++; if (a_s1h[0] !== 1'b0 || a_s1v[31:0] !== 32'h0 || b_s1h[0] !== 1'b0) begin mismatched++; $display("FAIL flush_after: got %b/%h b %b want 0/0 0", a_s1h[0], a_s1v[31:0], b_s1h[0]); end
        compared++; if (a_s2h[0] !== 1'b0 || b_s2h[0] !== 1'b0) begin mismatched++; $display("FAIL flush_nocapture: got %b/%b want 0/0", a_s2h[0], b_s2h[0]); end
        tick();
    endtask

    task automatic test_preg0();
        set_idle();
        put_wb(0, 0, 32'hFFFF_FFFF);
        #1;
        compared++; if ({a_s1h, a_s2h} !== '0 || {a_s1v, a_s2v} !== '0) begin mismatched++; $display("FAIL preg0_cur: got %b/%h want 0/0", {a_s1h, a_s2h}, {a_s1v, a_s2v}); end
        tick();
        wb_valid = '0;
        #1;
        compared++; if ({a_s1h, a_s2h, b_s1h, b_s2h} !== '0 || {b_s1v, b_s2v} !== '0) begin mismatched++; $display("FAIL preg0_buf: got %b want 0", {a_s1h, a_s2h, b_s1h, b_s2h}); end
        tick();
    endtask

    task automatic test_random();
        int tag;
        bit eh;
        logic [31:0] ev;
        for (int i = 0; i < 400; i++) begin
            rst = (i == 200);
            flush = ($urandom_range(15) == 0);
            for (int c = 0; c < NW; c++) begin
                wb_valid[c] = $urandom_range(1);
                wb_preg[c*PW +: PW] = PW'($urandom_range(15));
                wb_data[c*32 +: 32] = $urandom;
            end
            if (wb_valid[0] && wb_valid[1] && wb_preg[0 +: PW] == wb_preg[PW +: PW] && wb_preg[0 +: PW] != '0)
                wb_valid[1] = 1'b0;
            for (int r = 0; r < NR; r++) begin
                src1_reg[r*PW +: PW] = PW'($urandom_range(15));
                src2_reg[r*PW +: PW] = PW'($urandom_range(15));
            end
            #1;
            for (int r = 0; r < NR; r++) begin
                tag = int'(src1_reg[r*PW +: PW]);
                ref_lookup(tag, 1'b1, eh, ev);
                compared++; if (a_s1h[r] !== eh || a_s1v[r*32 +: 32] !== ev) begin mismatched++; $display("FAIL rnd_a_src1 cyc %0d port %0d: got %b/%h want %b/%h", i, r, a_s1h[r], a_s1v[r*32 +: 32], eh, ev); end
                ref_lookup(tag, 1'b0, eh, ev);
                compared++; if (b_s1h[r] !== eh || b_s1v[r*32 +: 32] !== ev) begin mismatched++; $display("FAIL rnd_b_src1 cyc %0d port %0d: got %b/%h want %b/%h", i, r, b_s1h[r], b_s1v[r*32 +: 32], eh, ev); end
                tag = int'(src2_reg[r*PW +: PW]);
                ref_lookup(tag, 1'b1, eh, ev);
                compared++; if (a_s2h[r] !== eh || a_s2v[r*32 +: 32] !== ev) begin mismatched++; $display("FAIL rnd_a_src2 cyc %0d port %0d: got %b/%h want %b/%h", i, r, a_s2h[r], a_s2v[r*32 +: 32], eh, ev); end
                ref_lookup(tag, 1'b0, eh, ev);
                compared++; if (b_s2h[r] !== eh || b_s2v[r*32 +: 32] !== ev) begin mismatched++; $display("FAIL rnd_b_src2 cyc %0d port %0d: got %b/%h want %b/%h", i, r, b_s2h[r], b_s2v[r*32 +: 32], eh, ev); end
            end
            compared++; if (a_cnt !== cnt_a[31:0] || b_cnt !== cnt_b[3:0]) begin mismatched++; $display("FAIL rnd_cnt cyc %0d: got %0d/%0d want %0d/%0d", i, a_cnt, b_cnt, cnt_a, cnt_b); end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_b [6] = '{0, 4, 8, 12, 15, 15};
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        put_wb(0, 1, 32'h11);
        put_wb(1, 2, 32'h22);
        tick();
        src1_reg = {6'd2, 6'd1};
        src2_reg = {6'd1, 6'd2};
        for (int k = 0; k < 6; k++) begin
            #1;
            compared++; if (b_cnt !== 4'(exp_b[k])) begin mismatched++; $display("FAIL sat_cnt step %0d: got %0d want %0d", k, b_cnt, exp_b[k]); end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_valid = '0;
        #1;
        compared++; if (b_cnt !== 4'd0 || a_cnt !== 32'd0) begin mismatched++; $display("FAIL sat_rst_cnt: got %0d/%0d want 0/0", b_cnt, a_cnt); end
        compared++; if ({a_s1h, a_s2h, b_s1h, b_s2h} !== '0) begin mismatched++; $display("FAIL sat_rst_empty: got %b want 0", {a_s1h, a_s2h, b_s1h, b_s2h}); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        for (int a = 1; a <= DP; a++)
            for (int c = 0; c < NW; c++) begin hv[a][c] = 1'b0; hp[a][c] = 0; hd[a][c] = '0; end
        test_reset();
        test_comb_byp();
        test_priority();
        test_flush();
        test_preg0();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
